evolution_ctrl: RTL

//  Owns the player Pokemon's progression state: poke ID, level and experience.

---
 rtl/evo_pkg.sv | 19 +
 rtl/evo_lookup.sv | 21 ++
 rtl/evolution_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/evo_pkg.sv
// Shared types and constants for the Pokemon progression controller.
package evo_pkg;

   typedef logic [4:0] poke_id_t;
   typedef logic [3:0] level_t;

   typedef enum logic [2:0] {
      IDLE,
      ADD,
      CHECK,
      EVOLVE,
      FIN
   } evo_state_e;

   // Levels that must be exceeded for the first and second evolution stage.
   localparam int STAGE1_LVL = 5;
   localparam int STAGE2_LVL = 11;

endpackage

// File: rtl/evo_lookup.sv
// Evolution rule table: maps (poke_id, level) to the ID it should become.
// IDs without an evolution at this level map to themselves.
module evo_lookup
   import evo_pkg::*;
(
   input  poke_id_t poke_id,
   input  level_t   level,
   output poke_id_t tgt
);

   // First stage 3,4,5 -> 6,7,8; second stage 6,7,8 -> 9,10,11.
   always_comb begin
      tgt = poke_id;
      if ((poke_id >= 5'd3) && (poke_id <= 5'd5) && (level > level_t'(STAGE1_LVL))) begin
         tgt = poke_id + 5'd3;
      end else if ((poke_id >= 5'd6) && (poke_id <= 5'd8) && (level > level_t'(STAGE2_LVL))) begin
         tgt = poke_id + 5'd3;
      end
   end

endmodule

// File: rtl/evolution_ctrl.sv
// Player progression controller: XP award -> level-ups -> evolution check ->
// evolution animation -> ID commit. XP handshake: a transfer happens on a
// clock edge where xp_valid & xp_ready are both high; xp_ready is high only
// in IDLE, and init_valid in the same cycle takes priority (no transfer).
module evolution_ctrl
   import evo_pkg::*;
#(
   parameter int XP_PER_LEVEL = 100,
   parameter int MAX_LEVEL    = 15,
   parameter int ANIM_CYCLES  = 64,
   parameter int BLINK_SHIFT  = 3
) (
   input  logic     Clk,
   input  logic     Reset_n,
   input  logic     init_valid,
   input  poke_id_t init_id,
   input  level_t   init_level,
   input  logic     xp_valid,
   input  logic [7:0] xp_amt,
   output logic     xp_ready,
   input  logic     cancel,
   output poke_id_t poke_id,
   output level_t   level,
   output logic [7:0] xp,
   output logic     busy,
   output logic     levelup,
   output logic     evo_active,
   output logic     evo_blink,
   output poke_id_t evo_new_id,
   output logic     evolved,
   output logic     done
);

   // Counter must reach ANIM_CYCLES-1 and also own the blink bit.
   localparam int CNT_W = ($clog2(ANIM_CYCLES) > (BLINK_SHIFT + 1)) ?
                          $clog2(ANIM_CYCLES) : (BLINK_SHIFT + 1);
   localparam logic [8:0]       XP_STEP   = 9'(XP_PER_LEVEL);
   localparam level_t           LVL_CAP   = level_t'(MAX_LEVEL);
   localparam logic [CNT_W-1:0] ANIM_LAST = CNT_W'(ANIM_CYCLES - 1);

   evo_state_e       state_q, state_d;
   poke_id_t         poke_id_q, poke_id_d;
   poke_id_t         evo_new_id_q, evo_new_id_d;
   poke_id_t         tgt;
   level_t           level_q, level_d;
   logic [8:0]       xp9_q, xp9_d;
   logic [CNT_W-1:0] anim_cnt_q, anim_cnt_d;
   logic             levelup_q, levelup_d;
   logic             evolved_q, evolved_d;
   logic             done_q, done_d;
   logic             evo_blink_q, evo_blink_d;
   logic             at_cap, can_level, evo_hit, anim_last;

   evo_lookup u_lookup (
      .poke_id (poke_id_q),
      .level   (level_q),
      .tgt     (tgt)
   );

   assign at_cap    = (level_q == LVL_CAP);
   assign can_level = (xp9_q >= XP_STEP);
   assign evo_hit   = (tgt != poke_id_q);
   assign anim_last = (anim_cnt_q == ANIM_LAST);

   // State register.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: one decision per cycle; cancel beats animation completion.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (!init_valid && xp_valid) state_d = ADD;
         ADD:     state_d = (!at_cap && can_level) ? CHECK : FIN;
         CHECK:   state_d = evo_hit ? EVOLVE : ADD;
         EVOLVE:  if (cancel || anim_last) state_d = ADD;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath and pulse next-values; pulses are registered so they line up
   // with the state they describe (levelup in CHECK, evolved with the commit,
   // done in FIN).
   always_comb begin
      poke_id_d    = poke_id_q;
      level_d      = level_q;
      xp9_d        = xp9_q;
      evo_new_id_d = evo_new_id_q;
      anim_cnt_d   = anim_cnt_q;
      levelup_d    = 1'b0;
      evolved_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (init_valid) begin
               poke_id_d = init_id;
               level_d   = init_level;
               xp9_d     = 9'd0;
            end else if (xp_valid) begin
               xp9_d = {1'b0, xp9_q[7:0]} + {1'b0, xp_amt};
            end
         end
         ADD: begin
            if (at_cap) begin
               xp9_d = 9'd0;
            end else if (can_level) begin
               xp9_d     = xp9_q - XP_STEP;
               level_d   = level_q + 4'd1;
               levelup_d = 1'b1;
            end
         end
         CHECK: begin
            if (evo_hit) begin
               evo_new_id_d = tgt;
               anim_cnt_d   = '0;
            end
         end
         EVOLVE: begin
            anim_cnt_d = anim_cnt_q + CNT_W'(1);
            if (!cancel && anim_last) begin
               poke_id_d = evo_new_id_q;
               evolved_d = 1'b1;
            end
         end
         default: ;
      endcase
      done_d      = (state_d == FIN);
      evo_blink_d = (state_d == EVOLVE) && anim_cnt_d[BLINK_SHIFT];
   end

   // Datapath and output registers; reset aborts any pending commit.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         poke_id_q    <= '0;
         level_q      <= 4'd1;
         xp9_q        <= '0;
         evo_new_id_q <= '0;
         anim_cnt_q   <= '0;
         levelup_q    <= 1'b0;
         evolved_q    <= 1'b0;
         done_q       <= 1'b0;
         evo_blink_q  <= 1'b0;
      end else begin
         poke_id_q    <= poke_id_d;
         level_q      <= level_d;
         xp9_q        <= xp9_d;
         evo_new_id_q <= evo_new_id_d;
         anim_cnt_q   <= anim_cnt_d;
         levelup_q    <= levelup_d;
         evolved_q    <= evolved_d;
         done_q       <= done_d;
         evo_blink_q  <= evo_blink_d;
      end
   end

   // Outputs: state-decoded handshake/status plus registered values.
   always_comb begin
      xp_ready   = (state_q == IDLE);
      busy       = (state_q != IDLE);
      evo_active = (state_q == EVOLVE);
      poke_id    = poke_id_q;
      level      = level_q;
      xp         = xp9_q[7:0];
      levelup    = levelup_q;
      evolved    = evolved_q;
      done       = done_q;
      evo_blink  = evo_blink_q;
      evo_new_id = evo_new_id_q;
   end

endmodule
